xpt2046_touch_reader: RTL and testbench

- SPI master and sample conditioner for the XPT2046 resistive-touch controller on the MSP2807 panel.
- Polls X/Y raw ADC values while the pen is down and averages 4 samples per axis.
- Drives the x_touch / y_touch / touch_input bus consumed directly by the colour-choice and cube-face screen blocks.

---
 rtl/xpt2046_touch_reader.sv | 176 +++++++++++++++++
 tb/tb_xpt2046_touch_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpt2046_touch_reader.sv
// rtl/xpt2046_touch_reader.sv - XPT2046 SPI poller with per-axis burst averaging
// Pen-down triggers bursts of alternating X/Y conversions; averaged results publish once per burst.
module xpt2046_touch_reader #(
  parameter int CLK_DIV        = 2,
  parameter int NUM_AVG_LOG2   = 2,
  parameter int GAP_CYCLES     = 1000,
  parameter int RELEASE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        penirq_n,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [11:0] x_touch,
  output logic [11:0] y_touch,
  output logic        touch_input,
  output logic        sample_valid
);

  localparam int ACC_W = 12 + NUM_AVG_LOG2;
  localparam int IDX_W = NUM_AVG_LOG2 + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_MAX  = REL_W'(RELEASE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, PUBLISH, GAP} state_t;

  state_t             state;
  logic [1:0]         pen_sync;
  logic [7:0]         div_cnt;
  logic [4:0]         edge_cnt;
  logic [7:0]         tx_sr;
  logic [11:0]        rx_sr;
  logic [IDX_W-1:0]   xfer_idx;
  logic [ACC_W-1:0]   acc_x;
  logic [ACC_W-1:0]   acc_y;
  logic [GAP_W-1:0]   gap_cnt;
  logic [REL_W-1:0]   rel_cnt;
  logic               pen_down;
  logic               axis_y;
  logic [7:0]         cmd;

  assign pen_down = ~pen_sync[1];
  assign axis_y   = xfer_idx[0];
  assign cmd      = axis_y ? 8'h90 : 8'hD0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pen_sync     <= 2'b11;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      xfer_idx     <= '0;
      acc_x        <= '0;
      acc_y        <= '0;
      gap_cnt      <= '0;
      rel_cnt      <= '0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      x_touch      <= '0;
      y_touch      <= '0;
      touch_input  <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      pen_sync     <= {pen_sync[0], penirq_n};
      sample_valid <= 1'b0;

      // PENIRQ is only meaningful while CS is high, so release timing runs in IDLE/GAP only.
      if (state == IDLE || state == GAP) begin
        if (pen_down) begin
          rel_cnt <= '0;
        end else begin
          if (rel_cnt != REL_MAX) rel_cnt <= rel_cnt + REL_W'(1);
          if (rel_cnt >= REL_MAX - REL_W'(1)) touch_input <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          acc_x    <= '0;
          acc_y    <= '0;
          xfer_idx <= '0;
          if (pen_down) begin
            div_cnt <= '0;
            state   <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          spi_cs_n <= 1'b0;
          spi_mosi <= cmd[7];
          tx_sr    <= {cmd[6:0], 1'b0};
          edge_cnt <= '0;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              edge_cnt <= edge_cnt + 5'd1;
              // edge_cnt holds the previous edge count, so 9..20 selects rising edges 10..21
              if (edge_cnt >= 5'd9 && edge_cnt <= 5'd20) rx_sr <= {rx_sr[10:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              spi_mosi <= tx_sr[7];
              tx_sr    <= {tx_sr[6:0], 1'b0};
              if (edge_cnt == 5'd24) begin
                state <= CS_HOLD;
                if (axis_y) acc_y <= acc_y + {{NUM_AVG_LOG2{1'b0}}, rx_sr};
                else        acc_x <= acc_x + {{NUM_AVG_LOG2{1'b0}}, rx_sr};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            spi_cs_n <= 1'b1;
            if (xfer_idx == IDX_LAST) begin
              state <= PUBLISH;
            end else if (pen_down) begin
              xfer_idx <= xfer_idx + IDX_W'(1);
              state    <= CS_SETUP;
            end else begin
              acc_x    <= '0;
              acc_y    <= '0;
              xfer_idx <= '0;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PUBLISH: begin
          x_touch      <= acc_x[ACC_W-1:NUM_AVG_LOG2];
          y_touch      <= acc_y[ACC_W-1:NUM_AVG_LOG2];
          sample_valid <= 1'b1;
          touch_input  <= 1'b1;
          rel_cnt      <= '0;
          gap_cnt      <= '0;
          state        <= GAP;
        end
        GAP: begin
          acc_x    <= '0;
          acc_y    <= '0;
          xfer_idx <= '0;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            div_cnt <= '0;
            state   <= pen_down ? CS_SETUP : IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpt2046_touch_reader.sv
// tb/tb_xpt2046_touch_reader.sv - self-checking bench with an XPT2046 slave model and result scoreboard
module tb_xpt2046_touch_reader;

  localparam int GAP = 200;
  localparam int REL = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        penirq_n;
  logic        spi_miso = 1'b0;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic [11:0] x_touch;
  logic [11:0] y_touch;
  logic        touch_input;
  logic        sample_valid;

  xpt2046_touch_reader #(
    .CLK_DIV(2), .NUM_AVG_LOG2(2), .GAP_CYCLES(GAP), .RELEASE_CYCLES(REL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .penirq_n(penirq_n), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .x_touch(x_touch), .y_touch(y_touch), .touch_input(touch_input),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][11:0] xs;
    logic [3:0][11:0] ys;
    logic [11:0]      x_exp;
    logic [11:0]      y_exp;
  } vec_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  int tests = 0;
  int fails = 0;

  logic [11:0] x_q[$];
  logic [11:0] y_q[$];
  exp_t        exp_q[$];
  int          sv_count = 0;

  int          rise_cnt = 0;
  int          total_rises = 0;
  logic [23:0] frame = '0;
  logic [11:0] cur_data = '0;
  logic        exp_x = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: record MOSI on rising edges, choose the conversion result once the command byte is in.
  always @(posedge spi_sclk or negedge spi_cs_n or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt = 0;
      exp_x    = 1'b1;
    end else if (spi_sclk) begin
      rise_cnt++;
      total_rises++;
      frame = {frame[22:0], spi_mosi};
      if (rise_cnt == 8) begin
        check("mosi_cmd", int'(frame[7:0]), exp_x ? 32'hD0 : 32'h90);
        if (frame[7:0] == 8'hD0) begin
          if (x_q.size() != 0) cur_data = x_q.pop_front();
          else cur_data = '0;
        end else begin
          if (y_q.size() != 0) cur_data = y_q.pop_front();
          else cur_data = '0;
        end
        exp_x = !exp_x;
      end
    end else begin
      rise_cnt = 0;
      frame    = '0;
    end
  end

  // After falling edge k, present the bit the master samples on rising edge k+1 (D11 on edge 10).
  always @(negedge spi_sclk) begin
    if (rise_cnt >= 9 && rise_cnt <= 20) spi_miso = cur_data[20 - rise_cnt];
    else spi_miso = 1'b0;
  end

  always @(posedge spi_cs_n) begin
    if (rise_cnt == 24) check("mosi_tail_zero", int'(frame[15:0]), 0);
  end

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      exp_t e;
      sv_count++;
      check("sv_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("x_touch", int'(x_touch), int'(e.x));
        check("y_touch", int'(y_touch), int'(e.y));
      end
    end
  end

  task automatic load_vec(input vec_t v, input bit expect_publish);
    x_q.delete();
    y_q.delete();
    for (int k = 0; k < 4; k++) begin
      x_q.push_back(v.xs[k]);
      y_q.push_back(v.ys[k]);
    end
    if (expect_publish) exp_q.push_back({v.x_exp, v.y_exp});
  endtask

  task automatic wait_sv(input int base, input string name);
    int n = 0;
    while (sv_count == base && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sv_timeout"}, int'(sv_count != base), 1);
  endtask

  vec_t vecs[4];
  vec_t dummy;

  initial begin
    int n;
    int base;
    int cs_low;
    int rises;
    int zero_seen;
    int r0;
    logic prev;

    vecs[0] = '{xs: {12'h806, 12'h804, 12'h802, 12'h800}, ys: {12'h400, 12'h400, 12'h400, 12'h400},
                x_exp: 12'h803, y_exp: 12'h400};
    vecs[1] = '{xs: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, ys: {12'h000, 12'h000, 12'h000, 12'h000},
                x_exp: 12'hFFF, y_exp: 12'h000};
    vecs[2] = '{xs: {12'h003, 12'h003, 12'h002, 12'h001}, ys: {12'h000, 12'hFFF, 12'h000, 12'hFFF},
                x_exp: 12'h002, y_exp: 12'h7FF};
    vecs[3] = '{xs: {12'hABC, 12'h789, 12'h456, 12'h123}, ys: {12'h123, 12'h456, 12'h789, 12'hABC},
                x_exp: 12'h5EF, y_exp: 12'h5EF};
    dummy   = '{xs: {4{12'hAAA}}, ys: {4{12'h555}}, x_exp: 12'h000, y_exp: 12'h000};

    rst_n    = 1'b0;
    penirq_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", int'(spi_cs_n), 1);
    check("rst_sclk", int'(spi_sclk), 0);
    check("rst_mosi", int'(spi_mosi), 0);
    check("rst_x", int'(x_touch), 0);
    check("rst_y", int'(y_touch), 0);
    check("rst_touch", int'(touch_input), 0);
    check("rst_sv", int'(sample_valid), 0);
    rst_n = 1'b1;

    cs_low = 0;
    repeat (10000) begin
      @(negedge clk);
      if (!spi_cs_n) cs_low++;
    end
    check("idle_cs_low_cycles", cs_low, 0);
    check("idle_sclk_edges", total_rises, 0);
    check("idle_sv_pulses", sv_count, 0);
    check("idle_touch", int'(touch_input), 0);

    for (int i = 0; i < 4; i++) begin
      load_vec(vecs[i], 1'b1);
      base = sv_count;
      if (i == 0) begin
        penirq_n = 1'b0;
      end else begin
        n = 0;
        while (spi_cs_n && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check("burst_gap_spacing", int'(n >= GAP), 1);
      end
      wait_sv(base, "table");
      check("table_touch", int'(touch_input), 1);
    end

    // Pen lifted after three transactions: burst is dropped, last coordinates held.
    load_vec(dummy, 1'b0);
    base = sv_count;
    n = 0;
    while (spi_cs_n && n < 5000) begin
      @(negedge clk);
      n++;
    end
    rises = 0;
    prev  = spi_cs_n;
    n     = 0;
    while (rises < 3 && n < 2000) begin
      @(negedge clk);
      if (spi_cs_n && !prev) rises++;
      prev = spi_cs_n;
      n++;
    end
    check("abort_three_xfers", rises, 3);
    penirq_n = 1'b1;
    n = 0;
    while (touch_input && n < REL + 2000) begin
      @(negedge clk);
      n++;
    end
    check("release_not_early", int'(n >= REL), 1);
    check("release_not_late", int'(n <= REL + 400), 1);
    check("abort_no_sv", sv_count, base);
    check("abort_x_held", int'(x_touch), int'(vecs[3].x_exp));
    check("abort_y_held", int'(y_touch), int'(vecs[3].y_exp));

    // Short pen-up between bursts keeps touch_input asserted.
    load_vec(vecs[0], 1'b1);
    base = sv_count;
    penirq_n = 1'b0;
    wait_sv(base, "glitch_a");
    check("glitch_a_touch", int'(touch_input), 1);
    penirq_n  = 1'b1;
    zero_seen = 0;
    repeat (REL / 4) begin
      @(negedge clk);
      if (!touch_input) zero_seen++;
    end
    check("glitch_touch_held", zero_seen, 0);
    load_vec(vecs[2], 1'b1);
    base = sv_count;
    penirq_n = 1'b0;
    wait_sv(base, "glitch_b");
    check("glitch_b_touch", int'(touch_input), 1);

    // Reset during rising edge 15 of the next burst's first transaction.
    load_vec(dummy, 1'b0);
    base = sv_count;
    r0 = total_rises;
    n  = 0;
    while (total_rises < r0 + 15 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_edge15", int'(total_rises - r0 >= 15), 1);
    check("pre_reset_sclk_high", int'(spi_sclk), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_cs_n", int'(spi_cs_n), 1);
    check("async_rst_sclk", int'(spi_sclk), 0);
    check("async_rst_mosi", int'(spi_mosi), 0);
    check("async_rst_x", int'(x_touch), 0);
    check("async_rst_y", int'(y_touch), 0);
    check("async_rst_touch", int'(touch_input), 0);
    repeat (4) @(negedge clk);
    check("reset_no_sv", sv_count, base);
    load_vec(vecs[1], 1'b1);
    rst_n = 1'b1;
    wait_sv(base, "post_reset");
    check("post_reset_touch", int'(touch_input), 1);

    penirq_n = 1'b1;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
